// File: rtl/psg_env_mc.sv
// Time-multiplexed NCH-channel ADSR envelope generator; one channel is updated per tick_i.
// Define PSG_ENV_EXP_EN for exponential decay/release steps ((level>>3)+1); default is linear.
module psg_env_mc #(
    parameter int NCH = 4,
    parameter int EW  = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           tick_i,
    input  logic [NCH-1:0] gate_i,
    input  logic           cfg_we_i,
    input  logic [3:0]     cfg_ch_i,
    input  logic [15:0]    cfg_dat_i,
    output logic [EW-1:0]  env_o,
    output logic [3:0]     env_ch_o,
    output logic           env_vld_o,
    output logic [NCH-1:0] busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_DECAY,
        ST_SUSTAIN,
        ST_RELEASE
    } state_e;

    localparam logic [EW-1:0] LVL_MAX = '1;

    state_e        state_q [NCH];
    state_e        state_d [NCH];
    logic [EW-1:0] level_q [NCH];
    logic [EW-1:0] level_d [NCH];
    logic [14:0]   dcnt_q  [NCH];
    logic [14:0]   dcnt_d  [NCH];
    logic [15:0]   cfg_q   [NCH];
    logic [15:0]   cfg_d   [NCH];
    logic [NCH-1:0] gq_q, gq_d;

    logic [3:0]    slot_q, slot_d;
    logic [EW-1:0] env_q, env_d;
    logic [3:0]    env_ch_q, env_ch_d;
    logic          env_vld_q, env_vld_d;

    // Serviced-channel view
    state_e        cur_state;
    logic [EW-1:0] cur_level;
    logic [14:0]   cur_dcnt;
    logic [15:0]   cur_cfg;
    logic          cur_gq;
    logic          cur_gate;

    state_e        svc_state;
    logic [EW-1:0] svc_level;
    logic [14:0]   svc_dcnt;

    logic [3:0]    rate;
    logic [14:0]   rate_lim;
    logic          step_now;
    logic [15:0]   sus_rep;
    logic [EW-1:0] sus_lvl;
    logic [EW-1:0] step_sz;
    logic [EW:0]   dec_ext;
    logic [EW-1:0] lvl_inc;

    always_comb begin
        cur_state = ST_IDLE;
        cur_level = '0;
        cur_dcnt  = '0;
        cur_cfg   = '0;
        cur_gq    = 1'b0;
        cur_gate  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (slot_q == 4'(i)) begin
                cur_state = state_q[i];
                cur_level = level_q[i];
                cur_dcnt  = dcnt_q[i];
                cur_cfg   = cfg_q[i];
                cur_gq    = gq_q[i];
                cur_gate  = gate_i[i];
            end
        end
    end

    // Sustain nibble replicated to 16 bits, then truncated to the top EW bits.
    assign sus_rep = {4{cur_cfg[15:12]}};
    assign sus_lvl = sus_rep[15 -: EW];

`ifdef PSG_ENV_EXP_EN
    assign step_sz = (cur_level >> 3) + EW'(1);
`else
    assign step_sz = EW'(1);
`endif

    assign dec_ext  = {1'b0, cur_level} - {1'b0, step_sz};
    assign lvl_inc  = (cur_level == LVL_MAX) ? LVL_MAX : cur_level + EW'(1);
    assign rate_lim = (15'd1 << rate) - 15'd1;
    assign step_now = (cur_dcnt == rate_lim);

    always_comb begin
        rate = 4'd0;
        case (cur_state)
            ST_ATTACK:  rate = cur_cfg[7:4];
            ST_DECAY:   rate = cur_cfg[3:0];
            ST_RELEASE: rate = cur_cfg[11:8];
            default:    rate = 4'd0;
        endcase
    end

    // Gate edges override the step rule for the visit in which they are seen.
    always_comb begin
        svc_state = cur_state;
        svc_level = cur_level;
        svc_dcnt  = cur_dcnt;
        if (cur_gate && !cur_gq) begin
            svc_state = ST_ATTACK;
            svc_dcnt  = '0;
        end else if (!cur_gate && cur_gq && cur_state != ST_IDLE) begin
            svc_state = ST_RELEASE;
            svc_dcnt  = '0;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    svc_level = '0;
                    svc_dcnt  = '0;
                end
                ST_SUSTAIN: begin
                    svc_level = sus_lvl;
                end
                ST_ATTACK: begin
                    if (step_now) begin
                        svc_dcnt  = '0;
                        svc_level = lvl_inc;
                        if (lvl_inc == LVL_MAX) begin
                            svc_state = ST_DECAY;
                        end
                    end else begin
                        svc_dcnt = cur_dcnt + 15'd1;
                    end
                end
                ST_DECAY: begin
                    if (step_now) begin
                        svc_dcnt = '0;
                        if (dec_ext[EW] || dec_ext[EW-1:0] <= sus_lvl) begin
                            svc_level = sus_lvl;
                            svc_state = ST_SUSTAIN;
                        end else begin
                            svc_level = dec_ext[EW-1:0];
                        end
                    end else begin
                        svc_dcnt = cur_dcnt + 15'd1;
                    end
                end
                ST_RELEASE: begin
                    if (step_now) begin
                        svc_dcnt = '0;
                        if (cur_level <= step_sz) begin
                            svc_level = '0;
                            svc_state = ST_IDLE;
                        end else begin
                            svc_level = cur_level - step_sz;
                        end
                    end else begin
                        svc_dcnt = cur_dcnt + 15'd1;
                    end
                end
                default: begin
                    svc_state = ST_IDLE;
                    svc_level = '0;
                    svc_dcnt  = '0;
                end
            endcase
        end
    end

    // Config writes land in cfg_q at the same edge as a visit, so that visit still sees the old word.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            level_d[i] = level_q[i];
            dcnt_d[i]  = dcnt_q[i];
            cfg_d[i]   = cfg_q[i];
            gq_d[i]    = gq_q[i];
            if (cfg_we_i && cfg_ch_i == 4'(i)) begin
                cfg_d[i] = cfg_dat_i;
            end
            if (tick_i && slot_q == 4'(i)) begin
                state_d[i] = svc_state;
                level_d[i] = svc_level;
                dcnt_d[i]  = svc_dcnt;
                gq_d[i]    = cur_gate;
            end
        end
    end

    always_comb begin
        slot_d    = slot_q;
        env_d     = env_q;
        env_ch_d  = env_ch_q;
        env_vld_d = tick_i;
        if (tick_i) begin
            env_d    = svc_level;
            env_ch_d = slot_q;
            slot_d   = (slot_q == 4'(NCH - 1)) ? 4'd0 : slot_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q    <= '0;
            env_q     <= '0;
            env_ch_q  <= '0;
            env_vld_q <= 1'b0;
            gq_q      <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                level_q[i] <= '0;
                dcnt_q[i]  <= '0;
                cfg_q[i]   <= '0;
            end
        end else begin
            slot_q    <= slot_d;
            env_q     <= env_d;
            env_ch_q  <= env_ch_d;
            env_vld_q <= env_vld_d;
            gq_q      <= gq_d;
            state_q   <= state_d;
            level_q   <= level_d;
            dcnt_q    <= dcnt_d;
            cfg_q     <= cfg_d;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_busy
        assign busy_o[gi] = (state_q[gi] != ST_IDLE);
    end

    assign env_o     = env_q;
    assign env_ch_o  = env_ch_q;
    assign env_vld_o = env_vld_q;

endmodule

// File: tb/tb_psg_env_mc.sv
// Testbench for psg_env_mc: directed ADSR scenarios plus randomized gates/config against a visit-level model.
module tb_psg_env_mc;

    localparam int NCH  = 4;
    localparam int EW   = 8;
    localparam int LMAX = (1 << EW) - 1;
    localparam int P_IDLE = 0, P_ATK = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           tick_i = 1'b0;
    logic [NCH-1:0] gate_i = '0;
    logic           cfg_we_i = 1'b0;
    logic [3:0]     cfg_ch_i = '0;
    logic [15:0]    cfg_dat_i = '0;
    logic [EW-1:0]  env_o;
    logic [3:0]     env_ch_o;
    logic           env_vld_o;
    logic [NCH-1:0] busy_o;

    psg_env_mc #(.NCH(NCH), .EW(EW)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .tick_i    (tick_i),
        .gate_i    (gate_i),
        .cfg_we_i  (cfg_we_i),
        .cfg_ch_i  (cfg_ch_i),
        .cfg_dat_i (cfg_dat_i),
        .env_o     (env_o),
        .env_ch_o  (env_ch_o),
        .env_vld_o (env_vld_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: one entry per channel, advanced once per visit.
    int          m_phase [NCH];
    int          m_level [NCH];
    int          m_cnt   [NCH];
    bit          m_g     [NCH];
    logic [15:0] m_cfg   [NCH];
    int          m_slot;

    logic [31:0]    obs_env, obs_ch, obs_vld;
    logic [NCH-1:0] obs_busy, exp_busy;
    int             exp_env, exp_ch;

    function automatic int sus_of(input logic [15:0] c);
        logic [15:0] r;
        r = {4{c[15:12]}};
        return int'(r >> (16 - EW));
    endfunction

    function automatic int step_of(input int lvl);
`ifdef PSG_ENV_EXP_EN
        return lvl / 8 + 1;
`else
        return (lvl >= 0) ? 1 : 1;
`endif
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_phase[c] = P_IDLE;
            m_level[c] = 0;
            m_cnt[c]   = 0;
            m_g[c]     = 1'b0;
            m_cfg[c]   = '0;
        end
        m_slot = 0;
    endtask

    task automatic model_visit(input int ch);
        bit g;
        int rate, sz, sus;
        g    = gate_i[ch];
        sus  = sus_of(m_cfg[ch]);
        rate = 0;
        if (g && !m_g[ch]) begin
            m_phase[ch] = P_ATK;
            m_cnt[ch]   = 0;
        end else if (!g && m_g[ch] && m_phase[ch] != P_IDLE) begin
            m_phase[ch] = P_REL;
            m_cnt[ch]   = 0;
        end else if (m_phase[ch] == P_IDLE) begin
            m_level[ch] = 0;
            m_cnt[ch]   = 0;
        end else if (m_phase[ch] == P_SUS) begin
            m_level[ch] = sus;
        end else begin
            if (m_phase[ch] == P_ATK)      rate = int'(m_cfg[ch][7:4]);
            else if (m_phase[ch] == P_DEC) rate = int'(m_cfg[ch][3:0]);
            else                           rate = int'(m_cfg[ch][11:8]);
            m_cnt[ch]++;
            if (m_cnt[ch] == (1 << rate)) begin
                m_cnt[ch] = 0;
                sz = step_of(m_level[ch]);
                if (m_phase[ch] == P_ATK) begin
                    m_level[ch] = (m_level[ch] + 1 > LMAX) ? LMAX : m_level[ch] + 1;
                    if (m_level[ch] == LMAX) m_phase[ch] = P_DEC;
                end else if (m_phase[ch] == P_DEC) begin
                    if (m_level[ch] - sz <= sus) begin
                        m_level[ch] = sus;
                        m_phase[ch] = P_SUS;
                    end else begin
                        m_level[ch] = m_level[ch] - sz;
                    end
                end else begin
                    if (m_level[ch] - sz <= 0) begin
                        m_level[ch] = 0;
                        m_phase[ch] = P_IDLE;
                    end else begin
                        m_level[ch] = m_level[ch] - sz;
                    end
                end
            end
        end
        m_g[ch] = g;
    endtask

    // Drives one tick (optionally with a coincident config write) and collects observed/expected values.
    task automatic tick_once(input bit we, input int wch, input logic [15:0] wdat);
        @(negedge clk);
        tick_i    = 1'b1;
        cfg_we_i  = we;
        cfg_ch_i  = wch[3:0];
        cfg_dat_i = wdat;
        @(posedge clk);
        #1;
        tick_i   = 1'b0;
        cfg_we_i = 1'b0;
        obs_env  = 32'(env_o);
        obs_ch   = 32'(env_ch_o);
        obs_vld  = 32'(env_vld_o);
        obs_busy = busy_o;
        exp_ch   = m_slot;
        model_visit(m_slot);
        exp_env  = m_level[exp_ch];
        if (we && wch < NCH) m_cfg[wch] = wdat;
        m_slot = (m_slot + 1) % NCH;
        for (int c = 0; c < NCH; c++) exp_busy[c] = (m_phase[c] != P_IDLE);
        $display("[TB] tick ch=%0d env=%0h exp=%0h busy=%b", obs_ch, obs_env, exp_env, obs_busy);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input logic [15:0] dat);
        @(negedge clk);
        cfg_we_i  = 1'b1;
        cfg_ch_i  = ch[3:0];
        cfg_dat_i = dat;
        @(posedge clk);
        #1;
        cfg_we_i = 1'b0;
        if (ch < NCH) m_cfg[ch] = dat;
        $display("[TB] cfg ch=%0d dat=%04h", ch, dat);
    endtask

    task automatic test_reset();
        model_reset();
        rst_ni = 1'b0;
        #12;
        n_tests++;
        if (env_o !== '0) begin n_fail++; $display("FAIL reset_env got=%0h want=0", env_o); end
        n_tests++;
        if (env_ch_o !== '0) begin n_fail++; $display("FAIL reset_ch got=%0h want=0", env_ch_o); end
        n_tests++;
        if (env_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%b want=0", env_vld_o); end
        n_tests++;
        if (busy_o !== '0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic test_adsr_ch0();
        int v, zero_at;
        cfg_write(0, 16'h8000);
        gate_i[0] = 1'b1;
        v = 0;
        for (int t = 0; t < NCH * 381; t++) begin
            tick_once(1'b0, 0, 16'h0);
            n_tests++;
            if (obs_env !== exp_env || obs_ch !== exp_ch || obs_vld !== 1 || obs_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL adsr_tick got env=%0h ch=%0d vld=%0d busy=%b want env=%0h ch=%0d vld=1 busy=%b",
                         obs_env, obs_ch, obs_vld, obs_busy, exp_env, exp_ch, exp_busy);
            end
            if (exp_ch == 0) begin
                if (v == 255) begin
                    n_tests++;
                    if (obs_env !== 32'hFF) begin n_fail++; $display("FAIL attack_peak got=%0h want=ff", obs_env); end
                end
                if (v == 380) begin
                    n_tests++;
                    if (obs_env !== 32'h88 || obs_busy[0] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sustain_hold got env=%0h busy0=%b want env=88 busy0=1", obs_env, obs_busy[0]);
                    end
                end
                v++;
            end
        end
        cfg_write(0, 16'h8200);
        gate_i[0] = 1'b0;
        v = 0;
        zero_at = -1;
        for (int t = 0; t < NCH * 600 && zero_at < 0; t++) begin
            tick_once(1'b0, 0, 16'h0);
            n_tests++;
            if (obs_env !== exp_env || obs_ch !== exp_ch || obs_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL release_tick got env=%0h ch=%0d busy=%b want env=%0h ch=%0d busy=%b",
                         obs_env, obs_ch, obs_busy, exp_env, exp_ch, exp_busy);
            end
            if (exp_ch == 0) begin
                if (obs_env == 0 && zero_at < 0) zero_at = v;
                v++;
            end
        end
        n_tests++;
`ifdef PSG_ENV_EXP_EN
        if (zero_at <= 0) begin n_fail++; $display("FAIL release_len got=%0d want>0", zero_at); end
`else
        if (zero_at != 544) begin n_fail++; $display("FAIL release_len got=%0d want=544", zero_at); end
`endif
        n_tests++;
        if (obs_busy[0] !== 1'b0) begin n_fail++; $display("FAIL release_idle busy0 got=%b want=0", obs_busy[0]); end
    endtask

    task automatic test_retrigger();
        int lvl;
        bit found;
        cfg_write(1, 16'hF000);
        gate_i[1] = 1'b1;
        for (int t = 0; t < NCH * 300 && m_phase[1] != P_SUS; t++) begin
            tick_once(1'b0, 0, 16'h0);
            n_tests++;
            if (obs_env !== exp_env || obs_ch !== exp_ch || obs_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL retrig_rise got env=%0h ch=%0d want env=%0h ch=%0d", obs_env, obs_ch, exp_env, exp_ch);
            end
        end
        gate_i[1] = 1'b0;
        found = 1'b0;
        lvl = 0;
        for (int t = 0; t < NCH * 300 && !found; t++) begin
            tick_once(1'b0, 0, 16'h0);
            n_tests++;
            if (obs_env !== exp_env || obs_ch !== exp_ch || obs_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL retrig_rel got env=%0h ch=%0d want env=%0h ch=%0d", obs_env, obs_ch, exp_env, exp_ch);
            end
            if (exp_ch == 1 && m_phase[1] == P_REL && exp_env <= 'h40) begin
                found = 1'b1;
                lvl = exp_env;
            end
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL retrig_reach got=timeout want=level<=40"); end
        gate_i[1] = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < NCH; k++) begin
                tick_once(1'b0, 0, 16'h0);
                if (exp_ch == 1) break;
            end
            n_tests++;
            if (obs_ch !== 1 || obs_env !== 32'(lvl + pass) || obs_busy[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL retrig_visit%0d got ch=%0d env=%0h busy1=%b want ch=1 env=%0h busy1=1",
                         pass, obs_ch, obs_env, obs_busy[1], lvl + pass);
            end
        end
    endtask

    task automatic test_cfg_coincident();
        int seen;
        cfg_write(2, 16'h0000);
        gate_i[2] = 1'b1;
        seen = 0;
        for (int t = 0; t < NCH * 3 && seen < 2; t++) begin
            tick_once(1'b0, 0, 16'h0);
            n_tests++;
            if (obs_env !== exp_env || obs_ch !== exp_ch) begin
                n_fail++;
                $display("FAIL coinc_pre got env=%0h ch=%0d want env=%0h ch=%0d", obs_env, obs_ch, exp_env, exp_ch);
            end
            if (exp_ch == 2) seen++;
        end
        for (int t = 0; t < NCH && m_slot != 2; t++) tick_once(1'b0, 0, 16'h0);
        tick_once(1'b1, 2, 16'h0030);
        n_tests++;
        if (obs_ch !== 2 || obs_env !== 32'd2) begin
            n_fail++;
            $display("FAIL coinc_old_rate got ch=%0d env=%0h want ch=2 env=2", obs_ch, obs_env);
        end
        for (int k = 0; k < NCH; k++) begin
            tick_once(1'b0, 0, 16'h0);
            if (exp_ch == 2) break;
        end
        n_tests++;
        if (obs_ch !== 2 || obs_env !== 32'd2) begin
            n_fail++;
            $display("FAIL coinc_new_rate got ch=%0d env=%0h want ch=2 env=2", obs_ch, obs_env);
        end
    endtask

    task automatic test_cfg_ignored();
        cfg_write(5, 16'hFFFF);
        for (int t = 0; t < NCH * 2; t++) begin
            tick_once(1'b0, 0, 16'h0);
            n_tests++;
            if (obs_env !== exp_env || obs_ch !== exp_ch || obs_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL cfg_oob got env=%0h ch=%0d busy=%b want env=%0h ch=%0d busy=%b",
                         obs_env, obs_ch, obs_busy, exp_env, exp_ch, exp_busy);
            end
        end
    endtask

    task automatic test_random();
        bit          we;
        int          wch;
        logic [15:0] wdat;
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 7) == 0) gate_i[c] = ~gate_i[c];
            end
            we   = ($urandom_range(0, 5) == 0);
            wch  = $urandom_range(0, 6);
            wdat = 16'($urandom) & 16'hF111;
            if (we && $urandom_range(0, 1) == 0) begin
                cfg_write(wch, wdat);
                we = 1'b0;
            end
            tick_once(we, wch, wdat);
            n_tests++;
            if (obs_env !== exp_env || obs_ch !== exp_ch || obs_vld !== 1 || obs_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL random_tick got env=%0h ch=%0d vld=%0d busy=%b want env=%0h ch=%0d vld=1 busy=%b",
                         obs_env, obs_ch, obs_vld, obs_busy, exp_env, exp_ch, exp_busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        gate_i = '0;
        for (int t = 0; t < NCH * 2; t++) tick_once(1'b0, 0, 16'h0);
        cfg_write(3, 16'h0000);
        gate_i[3] = 1'b1;
        for (int t = 0; t < NCH * 3 || m_slot != 3; t++) tick_once(1'b0, 0, 16'h0);
        @(negedge clk);
        tick_i = 1'b1;
        @(posedge clk);
        #1;
        tick_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (env_o !== '0 || env_ch_o !== '0) begin
            n_fail++;
            $display("FAIL midrst_env got env=%0h ch=%0h want env=0 ch=0", env_o, env_ch_o);
        end
        n_tests++;
        if (env_vld_o !== 1'b0) begin n_fail++; $display("FAIL midrst_vld got=%b want=0", env_vld_o); end
        n_tests++;
        if (busy_o !== '0) begin n_fail++; $display("FAIL midrst_busy got=%b want=0", busy_o); end
        gate_i = '0;
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        tick_once(1'b0, 0, 16'h0);
        n_tests++;
        if (obs_ch !== 0 || obs_env !== 0 || obs_vld !== 1) begin
            n_fail++;
            $display("FAIL midrst_first got ch=%0d env=%0h vld=%0d want ch=0 env=0 vld=1", obs_ch, obs_env, obs_vld);
        end
    endtask

    initial begin
        test_reset();
        test_adsr_ch0();
        test_retrigger();
        test_cfg_coincident();
        test_cfg_ignored();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
